qpu_issue_unit: RTL and testbench

Timed issue stage downstream of the two-layer instruction scheduler. Accepts scheduled quantum instruction words in order, buffers them in a FIFO, and holds each head word until the local time counter reaches its `start_time`. It then presents the word, retagged as issued, to the per-FPGA functional units together with the target FPGA index decoded from `dest`.

---
 rtl/qpu_issue_unit.sv | 120 ++++++++++++
 tb/tb_qpu_issue_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/qpu_issue_unit.sv
// ============================================================================
// qpu_issue_unit : timed in-order issue stage (FIFO + start_time gate + issue reg)
// Optional macro : QCS_LATE_DROP_EN (pop and count late heads instead of issuing)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module qpu_issue_unit #(
  parameter int NUM_FPGA           = 64,
  parameter int NUM_QUBIT_PER_FPGA = 64,
  parameter int DEPTH              = 16,
  localparam int QW = $clog2(NUM_FPGA*NUM_QUBIT_PER_FPGA),
  localparam int IW = 3*QW+22,
  localparam int FW = $clog2(NUM_FPGA),
  localparam int CW = $clog2(DEPTH)+1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic          tick_en,
  output logic [15:0]   time_now,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [IW-1:0] issue_instr,
  output logic [FW-1:0] issue_fpga,
  output logic          issue_late,
  output logic [CW-1:0] count,
  output logic [15:0]   drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Head word without its status nibble; status is always rewritten on issue.
  logic [IW-5:0] head;
  logic [15:0]   diff;
  logic          nonempty, due, late, slot_free;
  logic          load, late_pop, pop;
  logic          accept, push, discard;
  logic          late_tag;
  logic [16:0]   drop_sum;
  logic [CW-1:0] count_next;

  assign head      = mem[rd_ptr][IW-1:4];
  assign diff      = head[15:0] - time_now;
  assign nonempty  = (count != '0);
  assign late      = diff[15];
  assign due       = nonempty && ((diff == 16'd0) || late);
  assign slot_free = (state != S_ISSUE) || issue_ready;

`ifdef QCS_LATE_DROP_EN
  assign late_pop = nonempty && late;
  assign load     = due && !late && slot_free;
  assign late_tag = 1'b0;
`else
  assign late_pop = 1'b0;
  assign load     = due && slot_free;
  assign late_tag = late;
`endif

  assign pop         = load || late_pop;
  assign in_ready    = (count != CW'(DEPTH)) && !rst;
  assign accept      = in_valid && in_ready;
  assign push        = accept && in_instr[3];
  assign discard     = accept && !in_instr[3];
  assign drop_sum    = {1'b0, drop_cnt} + 17'(discard) + 17'(late_pop);
  assign count_next  = count + CW'(push) - CW'(pop);
  assign issue_valid = (state == S_ISSUE);

  // Storage has no reset; occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      time_now    <= 16'd0;
      drop_cnt    <= 16'd0;
      issue_instr <= '0;
      issue_fpga  <= '0;
      issue_late  <= 1'b0;
    end else begin
      if (tick_en) time_now <= time_now + 16'd1;
      if (push)    wr_ptr   <= wr_ptr + AW'(1);
      if (pop)     rd_ptr   <= rd_ptr + AW'(1);
      count    <= count_next;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

      if (load) begin
        issue_instr <= {head, 4'b1100};
        issue_fpga  <= head[16+QW-1 -: FW];
        issue_late  <= late_tag;
        state       <= S_ISSUE;
      end else if ((state == S_ISSUE) && !issue_ready) begin
        state <= S_ISSUE;
      end else begin
        state <= (count_next != '0) ? S_WAIT : S_IDLE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qpu_issue_unit.sv
// ============================================================================
// tb_qpu_issue_unit : directed self-checking bench for qpu_issue_unit
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_qpu_issue_unit;

  localparam int QW = 12;
  localparam int IW = 3*QW+22;
  localparam int FW = 6;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_instr = '0;
  logic          tick_en = 1'b0;
  logic [15:0]   time_now;
  logic          issue_valid;
  logic          issue_ready = 1'b0;
  logic [IW-1:0] issue_instr;
  logic [FW-1:0] issue_fpga;
  logic          issue_late;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  qpu_issue_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .tick_en(tick_en), .time_now(time_now),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_fpga(issue_fpga),
    .issue_late(issue_late), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk(input logic [15:0] st, input logic [5:0] fpga,
                                       input logic [3:0] status);
    logic [IW-1:0] w;
    w = '0;
    w[IW-1 -: 2] = 2'b10;
    w[IW-3 -: QW] = 12'h123;
    w[IW-3-QW -: QW] = 12'h456;
    w[20 +: QW] = {fpga, 6'h2A};
    w[19:4] = st;
    w[3:0] = status;
    return w;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; in_valid = 1'b0; tick_en = 1'b0; issue_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    step();
    n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", issue_valid); end
    n_cmp++; if (issue_instr !== '0) begin n_err++; $display("FAIL rst_instr: got %h want 0", issue_instr); end
    n_cmp++; if (issue_fpga !== '0) begin n_err++; $display("FAIL rst_fpga: got %0d want 0", issue_fpga); end
    n_cmp++; if (issue_late !== 1'b0) begin n_err++; $display("FAIL rst_late: got %b want 0", issue_late); end
    n_cmp++; if (time_now !== 16'd0) begin n_err++; $display("FAIL rst_time: got %h want 0", time_now); end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_min_latency;
    apply_reset();
    issue_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(16'd0, 6'd5, 4'b1000);
    step();
    in_valid = 1'b0;
    n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL lat_e0_valid: got %b want 0", issue_valid); end
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL lat_e0_count: got %0d want 1", count); end
    step();
    n_cmp++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL lat_e1_valid: got %b want 1", issue_valid); end
    n_cmp++; if (issue_fpga !== 6'd5) begin n_err++; $display("FAIL lat_fpga: got %0d want 5", issue_fpga); end
    n_cmp++; if (issue_instr !== mk(16'd0, 6'd5, 4'b1100)) begin n_err++; $display("FAIL lat_instr: got %h want %h", issue_instr, mk(16'd0, 6'd5, 4'b1100)); end
    n_cmp++; if (issue_late !== 1'b0) begin n_err++; $display("FAIL lat_late: got %b want 0", issue_late); end
    step();
    n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL lat_retire: got %b want 0", issue_valid); end
  endtask

  task automatic test_timed;
    apply_reset();
    issue_ready = 1'b1; tick_en = 1'b1;
    in_valid = 1'b1; in_instr = mk(16'd3, 6'd7, 4'b1000);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL timed_early_%0d: got %b want 0 (time %0d)", i, issue_valid, time_now); end
      if (i < 2) step();
    end
    n_cmp++; if (time_now !== 16'd3) begin n_err++; $display("FAIL timed_time3: got %0d want 3", time_now); end
    step();
    n_cmp++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL timed_issue: got %b want 1", issue_valid); end
    n_cmp++; if (issue_fpga !== 6'd7) begin n_err++; $display("FAIL timed_fpga: got %0d want 7", issue_fpga); end
    tick_en = 1'b0;
  endtask

  task automatic test_full;
    apply_reset();
    issue_ready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      in_valid = 1'b1; in_instr = mk(16'd0, 6'(i), 4'b1010);
      step();
      if (i == 15) begin
        n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL full_count15: got %0d want 15", count); end
      end
    end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL full_count16: got %0d want 16", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    in_instr = mk(16'd0, 6'd40, 4'b1000);
    repeat (3) step();
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL full_hold: got %0d want 16", count); end
    in_valid = 1'b0;
    issue_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      n_cmp++; if (issue_valid !== 1'b1 || issue_fpga !== 6'(i)) begin n_err++; $display("FAIL full_order_%0d: got valid %b fpga %0d want 1/%0d", i, issue_valid, issue_fpga, i); end
      step();
    end
    n_cmp++; if (issue_valid !== 1'b0 || count !== 5'd0) begin n_err++; $display("FAIL full_drain: got valid %b count %0d want 0/0", issue_valid, count); end
  endtask

  task automatic test_drop;
    apply_reset();
    issue_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(16'd0, 6'd4, 4'b0100);
    step();
    n_cmp++; if (drop_cnt !== 16'd1 || count !== 5'd0) begin n_err++; $display("FAIL drop_cnt: got drop %0d count %0d want 1/0", drop_cnt, count); end
    in_instr = mk(16'd0, 6'd9, 4'b1000);
    step();
    in_valid = 1'b0;
    n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL drop_no_issue: got %b want 0", issue_valid); end
    step();
    n_cmp++; if (issue_valid !== 1'b1 || issue_fpga !== 6'd9) begin n_err++; $display("FAIL drop_valid_word: got valid %b fpga %0d want 1/9", issue_valid, issue_fpga); end
    step();
    n_cmp++; if (issue_valid !== 1'b0 || drop_cnt !== 16'd1) begin n_err++; $display("FAIL drop_only_one: got valid %b drop %0d want 0/1", issue_valid, drop_cnt); end
  endtask

  task automatic test_late_and_reset;
    apply_reset();
    tick_en = 1'b1;
    repeat (10) step();
    tick_en = 1'b0;
    n_cmp++; if (time_now !== 16'd10) begin n_err++; $display("FAIL late_time: got %0d want 10", time_now); end
    in_valid = 1'b1; in_instr = mk(16'd2, 6'd3, 4'b1000);
    step();
    in_valid = 1'b0;
    step();
`ifdef QCS_LATE_DROP_EN
    n_cmp++; if (issue_valid !== 1'b0 || drop_cnt !== 16'd1 || count !== 5'd0) begin n_err++; $display("FAIL late_drop: got valid %b drop %0d count %0d want 0/1/0", issue_valid, drop_cnt, count); end
`else
    n_cmp++; if (issue_valid !== 1'b1 || issue_late !== 1'b1 || issue_fpga !== 6'd3) begin n_err++; $display("FAIL late_issue: got valid %b late %b fpga %0d want 1/1/3", issue_valid, issue_late, issue_fpga); end
`endif
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = mk(16'd12, 6'(20 + i), 4'b1000);
      step();
    end
    tick_en = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
    step();
    n_cmp++; if (issue_valid !== 1'b0 || issue_instr !== '0 || issue_fpga !== '0 || issue_late !== 1'b0) begin n_err++; $display("FAIL mid_rst_issue: got valid %b instr %h fpga %0d late %b want all 0", issue_valid, issue_instr, issue_fpga, issue_late); end
    n_cmp++; if (time_now !== 16'd0 || count !== 5'd0 || drop_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt: got time %0d count %0d drop %0d want 0/0/0", time_now, count, drop_cnt); end
    rst = 1'b0; in_valid = 1'b0; tick_en = 1'b0;
  endtask

  task automatic test_wrap;
    apply_reset();
    issue_ready = 1'b1; tick_en = 1'b1;
    repeat (65534) step();
    n_cmp++; if (time_now !== 16'hFFFE) begin n_err++; $display("FAIL wrap_time: got %h want fffe", time_now); end
    in_valid = 1'b1; in_instr = mk(16'h0001, 6'd11, 4'b1000);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL wrap_early_%0d: got %b want 0 (time %h)", i, issue_valid, time_now); end
      if (i < 2) step();
    end
    step();
    n_cmp++; if (issue_valid !== 1'b1 || issue_late !== 1'b0 || issue_fpga !== 6'd11) begin n_err++; $display("FAIL wrap_issue: got valid %b late %b fpga %0d want 1/0/11", issue_valid, issue_late, issue_fpga); end
    n_cmp++; if (time_now !== 16'd2) begin n_err++; $display("FAIL wrap_time_after: got %h want 2", time_now); end
    tick_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_timed();
    test_full();
    test_drop();
    test_late_and_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
